// File: rtl/level_pkg.sv
// level_pkg
// Shared constants and helpers for the liquid-level sensor path.
//   SENSOR_W         : width of the raw sensor vector (bit 0 = lowest sensor)
//   LEVEL_W          : width of the encoded level (0..SENSOR_W)
//   DEBOUNCE_DEFAULT : default debounce hold time in clock cycles (10 ms @ 100 MHz)
//   is_thermometer() : 1 when the vector is a contiguous run of ones from bit 0
//   popcount()       : number of ones in the vector
package level_pkg;

   localparam int unsigned SENSOR_W         = 8;
   localparam int unsigned LEVEL_W          = 4;
   localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

   // A thermometer code has no zero below a one, so adding 1 clears every set
   // bit; an all-ones vector wraps to zero and also passes.
   function automatic logic is_thermometer(input logic [SENSOR_W-1:0] v);
      logic [SENSOR_W-1:0] inc;
      inc = v + SENSOR_W'(1);
      return (v & inc) == '0;
   endfunction

   function automatic logic [LEVEL_W-1:0] popcount(input logic [SENSOR_W-1:0] v);
      logic [LEVEL_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < SENSOR_W; i++) begin
         n = n + LEVEL_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer
// Two-flop synchronizer followed by a hold-time debouncer.
// Parameters:
//   WIDTH  : vector width
//   CYCLES : cycles a candidate must hold before it is accepted (>= 2)
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   din       in   raw asynchronous vector
//   stable    out  last accepted vector
//   candidate out  vector currently being qualified (the one committed on commit)
//   commit    out  one-cycle pulse; stable takes candidate at the end of this cycle
module input_debouncer #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stable,
   output logic [WIDTH-1:0] candidate,
   output logic             commit
);

   localparam int unsigned         CNT_W   = $clog2(CYCLES);
   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] stable_q;
   logic [CNT_W-1:0] cnt;

   // Commit is combinational so the encoder can register the level on the
   // same edge that updates the stable vector.
   always_comb begin
      commit = (cnt == CNT_MAX) && (cand != stable_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= '0;
         sync2    <= '0;
         cand     <= '0;
         stable_q <= '0;
         cnt      <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (commit) begin
            stable_q <= cand;
         end
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
         end else if (cand != stable_q) begin
            if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign stable    = stable_q;
   assign candidate = cand;

endmodule

// File: rtl/sensor_level_encoder.sv
// sensor_level_encoder
// Debounces an 8-bit liquid sensor vector and encodes it as a level 0..8.
// Optional feature macro: FAULT_LATCH_EN (sticky fault, cleared by fault_clear).
// Parameters:
//   DEBOUNCE_CYCLES : cycles a vector must hold before acceptance (>= 2)
// Ports:
//   clk_100MHz     in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   sensors_input  in   raw sensors, bit 0 = lowest, asynchronous
//   fault_clear    in   synchronous pulse clearing a latched fault
//   sensors_stable out  last accepted vector
//   level          out  level from the last valid accepted vector
//   level_valid    out  one-cycle strobe when level is updated
//   fault          out  accepted vector is not a thermometer code
module sensor_level_encoder
   import level_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic                clk_100MHz,
   input  logic                reset_n,
   input  logic [SENSOR_W-1:0] sensors_input,
   input  logic                fault_clear,
   output logic [SENSOR_W-1:0] sensors_stable,
   output logic [LEVEL_W-1:0]  level,
   output logic                level_valid,
   output logic                fault
);

   logic [SENSOR_W-1:0] candidate;
   logic                commit;
   logic                cand_valid;
   logic [LEVEL_W-1:0]  cand_level;

   input_debouncer #(
      .WIDTH  (SENSOR_W),
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk       (clk_100MHz),
      .rst_n     (reset_n),
      .din       (sensors_input),
      .stable    (sensors_stable),
      .candidate (candidate),
      .commit    (commit)
   );

   always_comb begin
      cand_valid = is_thermometer(candidate);
      cand_level = popcount(candidate);
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         level       <= '0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= 1'b0;
         if (commit && cand_valid) begin
            level       <= cand_level;
            level_valid <= 1'b1;
         end
      end
   end

`ifdef FAULT_LATCH_EN
   // An invalid commit outranks a simultaneous clear.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         fault <= 1'b0;
      end else if (commit && !cand_valid) begin
         fault <= 1'b1;
      end else if (fault_clear) begin
         fault <= 1'b0;
      end
   end
`else
   // fault mirrors validity of the accepted vector; fault_clear has no effect.
   logic unused_fault_clear;
   assign unused_fault_clear = fault_clear;

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         fault <= 1'b0;
      end else if (commit) begin
         fault <= !cand_valid;
      end
   end
`endif

endmodule

// File: tb/tb_sensor_level_encoder.sv
module tb_sensor_level_encoder;

   logic       clk_100MHz;
   logic       reset_n;
   logic [7:0] sensors_input;
   logic       fault_clear;
   logic [7:0] sensors_stable;
   logic [3:0] level;
   logic       level_valid;
   logic       fault;

   typedef struct {
      logic [3:0] lvl;
      logic [7:0] vec;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   compared = 0;
   int   failed   = 0;

   sensor_level_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .clk_100MHz     (clk_100MHz),
      .reset_n        (reset_n),
      .sensors_input  (sensors_input),
      .fault_clear    (fault_clear),
      .sensors_stable (sensors_stable),
      .level          (level),
      .level_valid    (level_valid),
      .fault          (fault)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   always @(posedge clk_100MHz) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_100MHz);
   endtask

   // Called right after a negedge: strobe expected DEBOUNCE_CYCLES+3 = 7 edges later.
   task automatic expect_strobe(input logic [3:0] lvl, input logic [7:0] vec);
      exp_t e;
      e.lvl = lvl;
      e.vec = vec;
      e.cyc = cyc + 7;
      exp_q.push_back(e);
   endtask

   task automatic chk_outputs(input string tag, input int stab, input int lvl, input int flt);
      chk({tag, ".stable"}, sensors_stable, stab);
      chk({tag, ".level"}, level, lvl);
      chk({tag, ".fault"}, fault, flt);
   endtask

   // Monitor: every strobe must match the head of the scoreboard, on the right edge.
   always @(negedge clk_100MHz) begin
      if (level_valid) begin
         compared++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL strobe: unexpected level_valid level=%0d stable=0x%0h cycle %0d",
                     level, sensors_stable, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (level !== e.lvl || sensors_stable !== e.vec || cyc != e.cyc) begin
               failed++;
               $display("FAIL strobe: got level=%0d stable=0x%0h cycle %0d expected level=%0d stable=0x%0h cycle %0d",
                        level, sensors_stable, cyc, e.lvl, e.vec, e.cyc);
            end
         end
      end
   end

   initial begin
      reset_n       = 1'b0;
      sensors_input = 8'h00;
      fault_clear   = 1'b0;
      step(3);
      chk("reset.valid", level_valid, 0);
      chk_outputs("reset", 8'h00, 0, 0);
      reset_n = 1'b1;
      step(10);
      chk_outputs("idle", 8'h00, 0, 0);

      // 0x00 -> 0x07
      sensors_input = 8'h07;
      expect_strobe(4'd3, 8'h07);
      step(10);
      chk_outputs("lvl3", 8'h07, 3, 0);

      // short bounce to 0x0F, back to 0x07: silently cancelled
      sensors_input = 8'h0F;
      step(2);
      sensors_input = 8'h07;
      step(10);
      chk_outputs("bounce", 8'h07, 3, 0);

      // 0xFF -> level 8
      sensors_input = 8'hFF;
      expect_strobe(4'd8, 8'hFF);
      step(10);
      chk_outputs("lvl8", 8'hFF, 8, 0);

      // invalid 0x11: fault, level holds, no strobe
      sensors_input = 8'h11;
      step(10);
      chk_outputs("gap", 8'h11, 8, 1);

      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      step(2);
`ifdef FAULT_LATCH_EN
      chk("clear.fault", fault, 0);
`else
      chk("clear.fault", fault, 1);
`endif

      // valid 0x01 -> level 1, fault gone
      sensors_input = 8'h01;
      expect_strobe(4'd1, 8'h01);
      step(10);
      chk_outputs("lvl1", 8'h01, 1, 0);

      // invalid commit coincides with fault_clear: fault must be set
      sensors_input = 8'h05;
      step(6);
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      step(3);
      chk_outputs("clr_vs_commit", 8'h05, 1, 1);

      // reset mid-debounce of 0x03
      sensors_input = 8'h03;
      step(2);
      reset_n = 1'b0;
      step(1);
      chk("midrst.valid", level_valid, 0);
      chk_outputs("midrst", 8'h00, 0, 0);
      step(2);
      reset_n = 1'b1;
      expect_strobe(4'd2, 8'h03);
      step(10);
      chk_outputs("lvl2", 8'h03, 2, 0);

      step(5);
      chk("pending_strobes", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
